// File: rtl/time_display_mux_if.sv
// Display-side bundle: enables and binary time counts in, multiplexed segment/anode drive out.
interface time_display_mux_if;
  logic       en;
  logic       dp_en;
  logic [5:0] count_sec;
  logic [5:0] count_min;
  logic [5:0] count_hrs;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;
  logic       frame_start;

  modport slave (
    input  en, dp_en, count_sec, count_min, count_hrs,
    output seg, an, dp, frame_start
  );

  modport master (
    output en, dp_en, count_sec, count_min, count_hrs,
    input  seg, an, dp, frame_start
  );
endinterface

// File: rtl/time_display_mux.sv
// Six-digit multiplexed seven-segment driver with per-frame snapshot and anti-ghost blanking.
// Outputs are registered, 1-cycle latency from scan state; free-running scan, no backpressure.
module time_display_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 4
) (
  input  logic               clk,
  input  logic               reset,
  time_display_mux_if.slave  bus
);

  localparam int              SW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SW-1:0]   SLOT_MAX  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0]   BLANK_END = SW'(BLANK_CYC);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [5:0] AN_OFF    = 6'h3F;

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    hrs_q, hrs_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          frame_start_q, frame_start_d;

  logic          frame_go;
  logic [5:0]    field;
  logic [3:0]    digit_val;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] bcd_units(input logic [5:0] v);
    logic [5:0] u;
    u = v % 6'd10;
    return u[3:0];
  endfunction

  always_comb begin
    slot_cnt_d    = slot_cnt_q;
    digit_idx_d   = digit_idx_q;
    sec_d         = sec_q;
    min_d         = min_q;
    hrs_d         = hrs_q;
    seg_d         = SEG_BLANK;
    an_d          = AN_OFF;
    dp_d          = 1'b1;
    frame_start_d = 1'b0;
    field         = 6'd0;
    digit_val     = 4'd0;

    frame_go = bus.en && (digit_idx_q == 3'd0) && (slot_cnt_q == '0);

    if (!bus.en) begin
      slot_cnt_d  = '0;
      digit_idx_d = 3'd0;
    end else if (slot_cnt_q == SLOT_MAX) begin
      slot_cnt_d  = '0;
      // Any out-of-range index recovers to digit 0 on the wrap.
      digit_idx_d = (digit_idx_q >= 3'd5) ? 3'd0 : digit_idx_q + 3'd1;
    end else begin
      slot_cnt_d  = slot_cnt_q + SW'(1);
    end

    if (frame_go) begin
      sec_d         = bus.count_sec;
      min_d         = bus.count_min;
      hrs_d         = bus.count_hrs;
      frame_start_d = 1'b1;
    end

    case (digit_idx_q)
      3'd0, 3'd1: field = sec_q;
      3'd2, 3'd3: field = min_q;
      default:    field = hrs_q;
    endcase
    digit_val = digit_idx_q[0] ? bcd_tens(field) : bcd_units(field);

    if (bus.en && (slot_cnt_q >= BLANK_END) && (digit_idx_q <= 3'd5)) begin
      an_d = ~(6'b000001 << digit_idx_q);
      if (field >= 6'd60)
        seg_d = SEG_DASH;
      else if ((digit_idx_q == 3'd5) && (hrs_q < 6'd10))
        seg_d = SEG_BLANK;
      else
        seg_d = seg_code(digit_val);
      dp_d = !(bus.dp_en && ((digit_idx_q == 3'd2) || (digit_idx_q == 3'd4)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= 3'd0;
      sec_q         <= 6'd0;
      min_q         <= 6'd0;
      hrs_q         <= 6'd0;
      seg_q         <= SEG_BLANK;
      an_q          <= AN_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      sec_q         <= sec_d;
      min_q         <= min_d;
      hrs_q         <= hrs_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;

endmodule
